// File: rtl/arb_req_ctrl.sv
// Requester front end for a fixed-priority arbiter: per-channel job counters,
// request/own/release sequencing, starvation timeout and grant-protocol checks.
module arb_req_ctrl #(
  parameter int N     = 3,
  parameter int CNT_W = 4,
  parameter int HOLD  = 4,
  parameter int TMO   = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] job_vld,
  output logic [N-1:0] req,
  input  logic [N-1:0] resp,
  output logic [N-1:0] done,
  output logic [N-1:0] job_ovf,
  output logic [N-1:0] tmo_err,
  output logic         proto_err
);

  localparam int WT_W = $clog2(TMO);
  localparam int HD_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] pend_q  [N];
  logic [CNT_W-1:0] pend_d  [N];
  logic [WT_W-1:0]  wait_q  [N];
  logic [WT_W-1:0]  wait_d  [N];
  logic [HD_W-1:0]  hold_q  [N];
  logic [HD_W-1:0]  hold_d  [N];
  logic [N-1:0]     req_q, req_d;
  logic [N-1:0]     tmo_q, tmo_d;
  logic             proto_q, proto_d;
  logic [N-1:0]     lost, stray;
  logic             multi;

  assign req       = req_q;
  assign tmo_err   = tmo_q;
  assign proto_err = proto_q;
  assign multi     = (resp & (resp - 1'b1)) != '0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      wait_d[i]  = wait_q[i];
      hold_d[i]  = hold_q[i];
      done[i]    = 1'b0;
      job_ovf[i] = 1'b0;
      lost[i]    = 1'b0;
      tmo_d[i]   = tmo_q[i];
      // A grant arriving in REL is the arbiter's one-cycle tail, not an error.
      stray[i]   = resp[i] && !req_q[i] && (state_q[i] != REL);

      // hold_q counts the OWN cycles still to run, including the current one
      case (state_q[i])
        REQ: begin
          if (resp[i]) begin
            if (HOLD == 1) begin
              done[i]    = 1'b1;
              state_d[i] = REL;
            end else begin
              state_d[i] = OWN;
              hold_d[i]  = HD_W'(HOLD - 1);
            end
          end else if (wait_q[i] == WT_W'(TMO - 1)) begin
            tmo_d[i]   = 1'b1;
            state_d[i] = REL;
          end else begin
            wait_d[i] = wait_q[i] + 1'b1;
          end
        end
        OWN: begin
          if (!resp[i]) begin
            lost[i]    = 1'b1;
            state_d[i] = REQ;
            wait_d[i]  = '0;
          end else if (hold_q[i] == HD_W'(1)) begin
            done[i]    = 1'b1;
            state_d[i] = REL;
          end else begin
            hold_d[i] = hold_q[i] - 1'b1;
          end
        end
        default: ;
      endcase

      case ({job_vld[i], done[i]})
        2'b10: begin
          if (pend_q[i] == PEND_MAX) job_ovf[i] = 1'b1;
          else                       pend_d[i]  = pend_q[i] + 1'b1;
        end
        2'b01:   pend_d[i] = pend_q[i] - 1'b1;
        default: ;
      endcase

      // Pending work leaves REL straight for REQ so req drops for one cycle only.
      if (state_q[i] == IDLE || state_q[i] == REL) begin
        wait_d[i]  = '0;
        state_d[i] = (pend_d[i] != '0) ? REQ : IDLE;
      end

      req_d[i] = (state_d[i] == REQ) || (state_d[i] == OWN);
    end
    proto_d = proto_q | multi | (|stray) | (|lost);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        pend_q[i]  <= '0;
        wait_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
      req_q   <= '0;
      tmo_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        pend_q[i]  <= pend_d[i];
        wait_q[i]  <= wait_d[i];
        hold_q[i]  <= hold_d[i];
      end
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      proto_q <= proto_d;
    end
  end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Scoreboard bench for arb_req_ctrl: a behavioural channel model predicts every
// cycle's outputs into a queue, a monitor pops and compares against the DUT.
module tb_arb_req_ctrl;
  localparam int N     = 3;
  localparam int CNT_W = 4;
  localparam int HOLD  = 4;
  localparam int TMO   = 15;
  localparam int MAXP  = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] job_vld = '0;
  logic [N-1:0] resp = '0;
  logic [N-1:0] req, done, job_ovf, tmo_err;
  logic         proto_err;

  arb_req_ctrl #(.N(N), .CNT_W(CNT_W), .HOLD(HOLD), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .job_vld(job_vld), .req(req), .resp(resp),
    .done(done), .job_ovf(job_ovf), .tmo_err(tmo_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] req, done, ovf, tmo;
    logic         proto;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, failures = 0, cyc = 0, mode = 0;
  logic [N-1:0] force_val = '0, last_req = '0, last_resp = '0;
  int   done_cnt[N], ovf_cnt[N], done_cyc[N];

  // Channel model: phase 0 idle, 1 requesting, 2 owning, 3 releasing.
  int   m_ph[N], m_pend[N], m_wt[N], m_g[N];
  bit   m_tmo[N];
  bit   m_proto;

  task automatic cmpv(input string nm, input int c, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, c, got, exp);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Environment arbiter: keeps a grant while its requester holds req, else lowest index wins.
  function automatic logic [N-1:0] arb(input logic [N-1:0] rq, input logic [N-1:0] rs);
    if ((rq & rs) != '0) return rs;
    return rq & (~rq + 1'b1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i] = 0; m_pend[i] = 0; m_wt[i] = 0; m_g[i] = 0; m_tmo[i] = 0;
    end
    m_proto = 0; last_req = '0; last_resp = '0;
  endtask

  task automatic model_step(input logic [N-1:0] jv, input logic [N-1:0] rp);
    exp_t e;
    logic [N-1:0] rq, dn, ov, tm;
    bit bad;
    if (!rst_n) model_reset();
    for (int i = 0; i < N; i++) begin
      rq[i] = rst_n && (m_ph[i] == 1 || m_ph[i] == 2);
      dn[i] = rst_n && rp[i] && ((m_ph[i] == 2 && m_g[i] + 1 == HOLD) || (m_ph[i] == 1 && HOLD == 1));
      ov[i] = rst_n && jv[i] && !dn[i] && m_pend[i] == MAXP;
      tm[i] = m_tmo[i];
    end
    e.cyc = cyc; e.req = rq; e.done = dn; e.ovf = ov; e.tmo = tm; e.proto = m_proto;
    sb_q.push_back(e);
    if (!rst_n) return;
    bad = $countones(rp) > 1;
    for (int i = 0; i < N; i++) begin
      if (rp[i] && !rq[i] && m_ph[i] != 3) bad = 1;
      if (m_ph[i] == 2 && !rp[i]) bad = 1;
      if (jv[i] && !dn[i]) begin
        if (m_pend[i] < MAXP) m_pend[i]++;
      end else if (dn[i] && !jv[i]) m_pend[i]--;
      case (m_ph[i])
        1: begin
          if (rp[i]) begin
            if (HOLD == 1) m_ph[i] = 3;
            else begin m_ph[i] = 2; m_g[i] = 1; end
          end else if (m_wt[i] == TMO - 1) begin
            m_tmo[i] = 1; m_ph[i] = 3;
          end else m_wt[i]++;
        end
        2: begin
          if (!rp[i]) begin m_ph[i] = 1; m_wt[i] = 0; end
          else if (dn[i]) m_ph[i] = 3;
          else m_g[i]++;
        end
        default: begin
          m_wt[i] = 0;
          m_ph[i] = (m_pend[i] > 0) ? 1 : 0;
        end
      endcase
    end
    if (bad) m_proto = 1;
    last_req = rq; last_resp = rp;
  endtask

  task automatic cycle(input logic [N-1:0] jv);
    logic [N-1:0] r;
    @(negedge clk);
    case (mode)
      1:       r = '0;
      2:       r = force_val;
      default: r = arb(last_req, last_resp);
    endcase
    job_vld = jv; resp = r;
    #1;
    model_step(jv, r);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin done_cnt[i] = 0; ovf_cnt[i] = 0; done_cyc[i] = -1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    idle(2);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mode = 0;
    clr_counts();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmpv("req", e.cyc, req, e.req);
        cmpv("done", e.cyc, done, e.done);
        cmpv("job_ovf", e.cyc, job_ovf, e.ovf);
        cmpv("tmo_err", e.cyc, tmo_err, e.tmo);
        cmpv("proto_err", e.cyc, {{(N-1){1'b0}}, proto_err}, {{(N-1){1'b0}}, e.proto});
        for (int i = 0; i < N; i++) begin
          if (done[i] === 1'b1) begin done_cnt[i]++; done_cyc[i] = e.cyc; end
          if (job_ovf[i] === 1'b1) ovf_cnt[i]++;
        end
      end
    end
  end

  initial begin : stim
    int c0;
    logic [N-1:0] jv;
    model_reset();
    clr_counts();
    idle(3);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single job on channel 0: grant two cycles after the pulse, done HOLD-1 later.
    c0 = cyc;
    cycle(3'b001);
    idle(10);
    #2;
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_done_cyc", done_cyc[0], c0 + 2 + HOLD - 1);

    // All three at once: served 0,1,2 with one release cycle between grants.
    do_reset();
    c0 = cyc;
    cycle(3'b111);
    idle(20);
    #2;
    chk("t2_done0_cyc", done_cyc[0], c0 + 5);
    chk("t2_done1_cyc", done_cyc[1], c0 + 10);
    chk("t2_done2_cyc", done_cyc[2], c0 + 15);
    chk("t2_errs", {tmo_err, proto_err}, 0);

    // Overflow and starvation timeout on channel 1.
    do_reset();
    mode = 1;
    for (int k = 0; k < 16; k++) cycle(3'b010);
    idle(4);
    #2;
    chk("t3_ovf_cnt", ovf_cnt[1], 1);
    chk("t3_tmo1", tmo_err[1], 1);
    chk("t3_req1_again", req[1], 1);

    // Grant pulled after two OWN cycles, then a full grant completes the job.
    do_reset();
    cycle(3'b100);
    idle(4);
    mode = 1;
    cycle('0);
    mode = 0;
    #2;
    chk("t4_no_done", done_cnt[2], 0);
    idle(12);
    #2;
    chk("t4_proto", proto_err, 1);
    chk("t4_done_cnt", done_cnt[2], 1);

    // Multi-hot grant, then async reset in the middle of an ownership.
    do_reset();
    mode = 2; force_val = 3'b011;
    cycle('0);
    mode = 0;
    cycle('0);
    #2;
    chk("t5_proto_set", proto_err, 1);
    cycle(3'b001);
    idle(3);
    @(posedge clk); #2;
    chk("t5_pre_rst_req0", req[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", req, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_flags", {tmo_err, proto_err}, 0);
    idle(2);
    @(posedge clk); #2;
    rst_n = 1'b1;
    clr_counts();
    idle(8);
    #2;
    chk("t5_no_req_after", req, 0);

    // New job in the cycle the previous one completes: second job follows.
    do_reset();
    cycle(3'b001);
    idle(4);
    cycle(3'b001);
    idle(15);
    #2;
    chk("t6_done_cnt", done_cnt[0], 2);
    chk("t6_errs", {tmo_err, proto_err}, 0);

    // Random traffic under the environment arbiter.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) jv[i] = ($urandom_range(0, 7) == 0);
      cycle(jv);
    end
    idle(2);

    @(negedge clk); #3;
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
